// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD display converter.
package bin_to_bcd_seq_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Digit code that forces a 7-segment decoder to its blank default
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Double-dabble digit correction: add 3 to any digit of 5 or more so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational per-digit add-3 correction used before each shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correct one BCD digit ahead of the shift
    assign dout = add3_if_ge5(din);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Signed operands are converted by magnitude; the sign is reported separately.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_INC  = CW'(1);

    logic [1:0]            state;
    logic [4*DIGITS-1:0]   acc;
    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_nxt;
    logic [WIDTH-1:0]      mag;
    logic [WIDTH-1:0]      neg_bin;
    logic                  sign_q;
    logic                  ovf_acc;
    logic                  ovf_nxt;
    logic                  operand_neg;
    logic [CW-1:0]         cnt;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (acc[4*g +: 4]),
                .dout (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // Two's-complement negate is taken modulo 2^WIDTH, so the most negative
    // operand maps exactly onto its unsigned magnitude.
    assign operand_neg = is_signed & binary[WIDTH-1];
    assign neg_bin     = ~binary + ONE;

    // Adjusted accumulator shifted left with the next operand bit; the bit
    // leaving the top digit means the value needs more than DIGITS digits.
    assign acc_nxt = {acc_adj[4*DIGITS-2:0], mag[WIDTH-1]};
    assign ovf_nxt = ovf_acc | acc_adj[4*DIGITS-1];

    // Control FSM, shift datapath and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            acc      <= '0;
            mag      <= '0;
            sign_q   <= 1'b0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mag     <= operand_neg ? neg_bin : binary;
                        sign_q  <= operand_neg;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc     <= acc_nxt;
                    mag     <= mag << 1;
                    ovf_acc <= ovf_nxt;
                    cnt     <= cnt + CNT_INC;
                    if (cnt == CNT_LAST) begin
                        bcd_out  <= acc_nxt;
                        negative <= sign_q;
                        overflow <= ovf_nxt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance share stimulus.
module tb_bin_to_bcd_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [15:0] binary;

    logic        busy5, done5, neg5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, neg4, ovf4;
    logic [15:0] bcd4;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] bin;
        logic        sgn;
        logic [19:0] bcd5;
        logic        neg;
        logic        ovf5;
        logic [15:0] bcd4;
        logic        ovf4;
    } vec_t;

    vec_t tbl[12];

    always #5 clock = ~clock;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .binary    (binary),
        .busy      (busy5),
        .done      (done5),
        .bcd_out   (bcd5),
        .negative  (neg5),
        .overflow  (ovf5)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .binary    (binary),
        .busy      (busy4),
        .done      (done4),
        .bcd_out   (bcd4),
        .negative  (neg4),
        .overflow  (ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One conversion: returns the cycle index (1 = cycle after the accepting
    // edge) at which done5 was first seen, and how many busy cycles preceded it.
    task automatic run_conv(input logic [15:0] bin, input logic sgn,
                            output int lat, output int busy_cnt);
        @(posedge clock); #1;
        binary    = bin;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done5) begin
                lat = k;
                break;
            end
            if (busy5) busy_cnt++;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int lat, bcnt, npulse, last_pulse, overlap, ndone;
        int pulse_at[8];

        tbl[0]  = '{16'd65535, 1'b0, 20'h65535, 1'b0, 1'b0, 16'h5535, 1'b1};
        tbl[1]  = '{16'hFFFF,  1'b1, 20'h00001, 1'b1, 1'b0, 16'h0001, 1'b0};
        tbl[2]  = '{16'h8000,  1'b1, 20'h32768, 1'b1, 1'b0, 16'h2768, 1'b1};
        tbl[3]  = '{16'h0000,  1'b1, 20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{16'd12345, 1'b0, 20'h12345, 1'b0, 1'b0, 16'h2345, 1'b1};
        tbl[5]  = '{16'd9999,  1'b0, 20'h09999, 1'b0, 1'b0, 16'h9999, 1'b0};
        tbl[6]  = '{16'h8000,  1'b0, 20'h32768, 1'b0, 1'b0, 16'h2768, 1'b1};
        tbl[7]  = '{16'h7FFF,  1'b1, 20'h32767, 1'b0, 1'b0, 16'h2767, 1'b1};
        tbl[8]  = '{16'hFF85,  1'b1, 20'h00123, 1'b1, 1'b0, 16'h0123, 1'b0};
        tbl[9]  = '{16'd10000, 1'b0, 20'h10000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[10] = '{16'd1,     1'b1, 20'h00001, 1'b0, 1'b0, 16'h0001, 1'b0};
        tbl[11] = '{16'd90,    1'b0, 20'h00090, 1'b0, 1'b0, 16'h0090, 1'b0};

        // Reset held with start asserted
        reset_n   = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        binary    = 16'd1234;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy",     32'(busy5), 32'd0);
        check("reset done",     32'(done5), 32'd0);
        check("reset bcd",      32'(bcd5),  32'd0);
        check("reset negative", 32'(neg5),  32'd0);
        check("reset overflow", 32'(ovf5),  32'd0);
        check("reset bcd4",     32'(bcd4),  32'd0);
        start   = 1'b0;
        reset_n = 1'b1;

        // Table of conversions on both instances
        for (int i = 0; i < 12; i++) begin
            run_conv(tbl[i].bin, tbl[i].sgn, lat, bcnt);
            check($sformatf("v%0d latency", i),   32'(lat),  32'd17);
            check($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'd16);
            check($sformatf("v%0d busy at done", i), 32'(busy5), 32'd0);
            check($sformatf("v%0d done4", i),     32'(done4), 32'd1);
            check($sformatf("v%0d bcd5", i),      32'(bcd5), 32'(tbl[i].bcd5));
            check($sformatf("v%0d neg5", i),      32'(neg5), 32'(tbl[i].neg));
            check($sformatf("v%0d ovf5", i),      32'(ovf5), 32'(tbl[i].ovf5));
            check($sformatf("v%0d bcd4", i),      32'(bcd4), 32'(tbl[i].bcd4));
            check($sformatf("v%0d neg4", i),      32'(neg4), 32'(tbl[i].neg));
            check($sformatf("v%0d ovf4", i),      32'(ovf4), 32'(tbl[i].ovf4));
        end

        // Done is a single-cycle pulse and outputs hold afterwards
        @(posedge clock); #1;
        check("done pulse width", 32'(done5), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        check("bcd holds", 32'(bcd5), 32'h00090);

        // start held high: one done pulse every WIDTH+2 cycles
        binary    = 16'd100;
        is_signed = 1'b0;
        start     = 1'b1;
        npulse    = 0;
        overlap   = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock); #1;
            if (busy5 && done5) overlap++;
            if (done5 && npulse < 8) begin
                pulse_at[npulse] = c;
                npulse++;
            end
        end
        start = 1'b0;
        check("held start pulses", 32'(npulse), 32'd5);
        check("held start first", 32'(pulse_at[0]), 32'd16);
        last_pulse = pulse_at[0];
        for (int p = 1; p < npulse && p < 8; p++) begin
            check($sformatf("held start spacing %0d", p), 32'(pulse_at[p] - last_pulse), 32'd18);
            last_pulse = pulse_at[p];
        end
        check("busy and done overlap", 32'(overlap), 32'd0);
        check("held start bcd", 32'(bcd5), 32'h00100);
        repeat (20) @(posedge clock);

        // Reset during SHIFT cycle 8 aborts the conversion
        @(posedge clock); #1;
        binary    = 16'd12345;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        check("abort busy before reset", 32'(busy5), 32'd1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("abort busy", 32'(busy5), 32'd0);
        check("abort done", 32'(done5), 32'd0);
        check("abort bcd",  32'(bcd5),  32'd0);
        check("abort bcd4", 32'(bcd4),  32'd0);
        check("abort ovf4", 32'(ovf4),  32'd0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clock); #1;
            if (done5 || done4 || busy5) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
